lane_frame_shifter: RTL and testbench

- Parametrised successor to the single-lane shift register. It moves a WIDTH-bit frame across LANES parallel serial lanes in full duplex.
- A parallel word is accepted over a valid/ready handshake and shifted out, while serial input is shifted in.
- The completed received frame is presented on a second valid/ready handshake.
- Sits between parallel datapath logic and serial pin/lane interfaces.

---
 rtl/lane_frame_shifter_if.sv | 46 ++++
 rtl/lane_frame_shifter.sv | 150 +++++++++++++++
 tb/tb_lane_frame_shifter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_frame_shifter_if.sv
// Handshake and serial-lane bundle for lane_frame_shifter.
// The slave modport is the shifter's view; master is the surrounding logic.
interface lane_frame_shifter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 1
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             shift_enable;
  logic [LANES-1:0] serial_in;
  logic [LANES-1:0] serial_out;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             busy;
  logic             frame_done;

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    input  shift_enable,
    input  serial_in,
    output serial_out,
    output rx_data,
    output rx_valid,
    input  rx_ready,
    output busy,
    output frame_done
  );

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    output shift_enable,
    output serial_in,
    input  serial_out,
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    input  busy,
    input  frame_done
  );
endinterface

// File: rtl/lane_frame_shifter.sv
// Full-duplex multi-lane frame shifter: loads a parallel frame, shifts it out over LANES
// serial lanes while shifting the received frame in, and hands the result off via valid/ready.
module lane_frame_shifter #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      LANES     = 1,
  parameter logic [WIDTH-1:0] RST_VALUE = '0,
  parameter bit               LSB_FIRST = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  lane_frame_shifter_if.slave bus
);

  localparam int unsigned BEATS = WIDTH / LANES;
  localparam int unsigned CntW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BEATS - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] shifted;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_done_q;

  logic last;
  logic beat_fire;
  logic complete;
  logic load;
  logic tx_ready;
  logic busy;

  assign last      = (cnt_q == LastCnt);
  // The final beat waits for the previous received frame to be taken so it is never overwritten.
  assign beat_fire = (state_q == StShift) && bus.shift_enable &&
                     (!last || !rx_valid_q || bus.rx_ready);
  assign complete  = beat_fire && last;
  assign load      = bus.tx_valid && tx_ready;

  // Per-lane shift network; lane l owns segment [l*BEATS +: BEATS].
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [BEATS-1:0] seg;
    assign seg = sr_q[l*BEATS +: BEATS];

    if (BEATS == 1) begin : g_single
      assign shifted[l*BEATS] = bus.serial_in[l];
    end else if (LSB_FIRST) begin : g_lsb
      assign shifted[l*BEATS +: BEATS] = {bus.serial_in[l], seg[BEATS-1:1]};
    end else begin : g_msb
      assign shifted[l*BEATS +: BEATS] = {seg[BEATS-2:0], bus.serial_in[l]};
    end

    if (LSB_FIRST) begin : g_out_lsb
      assign bus.serial_out[l] = seg[0];
    end else begin : g_out_msb
      assign bus.serial_out[l] = seg[BEATS-1];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.tx_valid) begin
          state_d = StShift;
        end
      end
      StShift: begin
        if (complete && !bus.tx_valid) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // FSM outputs; tx_ready on the final beat lets the next frame follow with no idle cycle.
  always_comb begin
    tx_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_ready = 1'b1;
      end
      StShift: begin
        busy     = 1'b1;
        tx_ready = complete;
      end
    endcase
  end

  // Datapath next state.
  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;

    if (load) begin
      sr_d  = bus.tx_data;
      cnt_d = '0;
    end else if (beat_fire) begin
      sr_d  = shifted;
      cnt_d = last ? '0 : cnt_q + CntW'(1);
    end

    // A completion replaces the held frame even if it is being consumed this cycle.
    if (complete) begin
      rx_data_d  = shifted;
      rx_valid_d = 1'b1;
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q         <= RST_VALUE;
      cnt_q        <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_done_q <= complete;
    end
  end

  assign bus.tx_ready   = tx_ready;
  assign bus.busy       = busy;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_lane_frame_shifter.sv
// Bench for lane_frame_shifter: three configurations share one random stimulus stream and are
// compared every cycle against a frame-level model that tracks bit positions rather than shifts.
module tb_lane_frame_shifter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       shift_enable = 1'b0;
  logic [7:0] serial_in = '0;
  logic       rx_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: 1 lane, LSB first. Instance 1: 2 lanes, MSB first. Instance 2: 8 lanes (1 beat).
  lane_frame_shifter_if #(.WIDTH(8), .LANES(1)) if_a ();
  lane_frame_shifter_if #(.WIDTH(8), .LANES(2)) if_b ();
  lane_frame_shifter_if #(.WIDTH(8), .LANES(8)) if_c ();

  lane_frame_shifter #(.WIDTH(8), .LANES(1), .RST_VALUE(8'hFF), .LSB_FIRST(1'b1)) u_dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_a.slave)
  );
  lane_frame_shifter #(.WIDTH(8), .LANES(2), .RST_VALUE(8'h5A), .LSB_FIRST(1'b0)) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_b.slave)
  );
  lane_frame_shifter #(.WIDTH(8), .LANES(8), .RST_VALUE(8'h3C), .LSB_FIRST(1'b1)) u_dut_c (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_c.slave)
  );

  assign if_a.tx_data = tx_data;
  assign if_b.tx_data = tx_data;
  assign if_c.tx_data = tx_data;
  assign if_a.tx_valid = tx_valid;
  assign if_b.tx_valid = tx_valid;
  assign if_c.tx_valid = tx_valid;
  assign if_a.shift_enable = shift_enable;
  assign if_b.shift_enable = shift_enable;
  assign if_c.shift_enable = shift_enable;
  assign if_a.serial_in = serial_in[0];
  assign if_b.serial_in = serial_in[1:0];
  assign if_c.serial_in = serial_in;
  assign if_a.rx_ready = rx_ready;
  assign if_b.rx_ready = rx_ready;
  assign if_c.rx_ready = rx_ready;

  logic [7:0] obs_so   [3];
  logic [7:0] obs_rxd  [3];
  logic       obs_txr  [3];
  logic       obs_busy [3];
  logic       obs_rxv  [3];
  logic       obs_fd   [3];

  assign obs_so[0] = {7'b0, if_a.serial_out};
  assign obs_so[1] = {6'b0, if_b.serial_out};
  assign obs_so[2] = if_c.serial_out;
  assign obs_rxd[0] = if_a.rx_data;
  assign obs_rxd[1] = if_b.rx_data;
  assign obs_rxd[2] = if_c.rx_data;
  assign obs_txr[0] = if_a.tx_ready;
  assign obs_txr[1] = if_b.tx_ready;
  assign obs_txr[2] = if_c.tx_ready;
  assign obs_busy[0] = if_a.busy;
  assign obs_busy[1] = if_b.busy;
  assign obs_busy[2] = if_c.busy;
  assign obs_rxv[0] = if_a.rx_valid;
  assign obs_rxv[1] = if_b.rx_valid;
  assign obs_rxv[2] = if_c.rx_valid;
  assign obs_fd[0] = if_a.frame_done;
  assign obs_fd[1] = if_b.frame_done;
  assign obs_fd[2] = if_c.frame_done;

  // Model state: the frame being sent (as loaded), beat index, and the bits received so far.
  logic [7:0] m_cur [3];
  logic [7:0] m_acc [3];
  logic [7:0] m_rxd [3];
  int         m_k   [3];
  bit         m_sh  [3];
  bit         m_rxv [3];
  bit         m_fd  [3];

  // Snapshot of instance 0 taken in the last run_cycle, for directed constant checks.
  logic       snap_so_a;
  logic [7:0] snap_rxd_a;
  logic       snap_rxv_a, snap_fd_a, snap_busy_a;

  function automatic int lanes_of(int i);
    case (i)
      0:       return 1;
      1:       return 2;
      default: return 8;
    endcase
  endfunction

  function automatic bit lsb_of(int i);
    return i != 1;
  endfunction

  function automatic logic [7:0] rst_of(int i);
    case (i)
      0:       return 8'hFF;
      1:       return 8'h5A;
      default: return 8'h3C;
    endcase
  endfunction

  // Frame bit that goes out (and the position a received bit lands in) on beat k of lane l.
  function automatic int bitpos(int i, int l, int k);
    int b;
    b = 8 / lanes_of(i);
    return l * b + (lsb_of(i) ? k : b - 1 - k);
  endfunction

  function automatic bit pred_fire(int i);
    int b;
    b = 8 / lanes_of(i);
    return m_sh[i] && shift_enable && ((m_k[i] != b - 1) || !m_rxv[i] || rx_ready);
  endfunction

  function automatic bit pred_complete(int i);
    int b;
    b = 8 / lanes_of(i);
    return pred_fire(i) && (m_k[i] == b - 1);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(int i);
    m_cur[i] = rst_of(i);
    m_acc[i] = '0;
    m_rxd[i] = '0;
    m_k[i]   = 0;
    m_sh[i]  = 1'b0;
    m_rxv[i] = 1'b0;
    m_fd[i]  = 1'b0;
  endtask

  task automatic model_step(int i);
    bit fire, comp, load;
    fire = pred_fire(i);
    comp = pred_complete(i);
    load = tx_valid && (!m_sh[i] || comp);
    if (fire) begin
      for (int l = 0; l < lanes_of(i); l++) m_acc[i][bitpos(i, l, m_k[i])] = serial_in[l];
    end
    m_fd[i] = comp;
    if (comp) begin
      m_rxd[i] = m_acc[i];
      m_rxv[i] = 1'b1;
    end else if (m_rxv[i] && rx_ready) begin
      m_rxv[i] = 1'b0;
    end
    if (load) begin
      m_cur[i] = tx_data;
      m_k[i]   = 0;
      m_sh[i]  = 1'b1;
    end else if (comp) begin
      m_cur[i] = m_acc[i];
      m_k[i]   = 0;
      m_sh[i]  = 1'b0;
    end else if (fire) begin
      m_k[i]++;
    end
  endtask

  task automatic check_inst(int i);
    logic [7:0] eso;
    eso = '0;
    for (int l = 0; l < lanes_of(i); l++) eso[l] = m_cur[i][bitpos(i, l, m_k[i])];
    check_val($sformatf("inst%0d serial_out", i), obs_so[i], eso);
    check_val($sformatf("inst%0d tx_ready", i), obs_txr[i], !m_sh[i] || pred_complete(i));
    check_val($sformatf("inst%0d busy", i), obs_busy[i], m_sh[i]);
    check_val($sformatf("inst%0d rx_data", i), obs_rxd[i], m_rxd[i]);
    check_val($sformatf("inst%0d rx_valid", i), obs_rxv[i], m_rxv[i]);
    check_val($sformatf("inst%0d frame_done", i), obs_fd[i], m_fd[i]);
  endtask

  task automatic run_cycle(input logic [7:0] td, input logic tv, input logic se,
                           input logic [7:0] si, input logic rr);
    @(negedge clk);
    tx_data      = td;
    tx_valid     = tv;
    shift_enable = se;
    serial_in    = si;
    rx_ready     = rr;
    #1;
    for (int i = 0; i < 3; i++) check_inst(i);
    snap_so_a   = obs_so[0][0];
    snap_rxd_a  = obs_rxd[0];
    snap_rxv_a  = obs_rxv[0];
    snap_fd_a   = obs_fd[0];
    snap_busy_a = obs_busy[0];
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must react before any edge.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst_n        = 1'b0;
    tx_valid     = 1'b0;
    shift_enable = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) model_reset(i);
    for (int i = 0; i < 3; i++) check_inst(i);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] pat_tx;
    logic [7:0] pat_rx;
    pat_tx = 8'hA5;
    pat_rx = 8'h3C;
    for (int i = 0; i < 3; i++) model_reset(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed frame on the single-lane instance: send 0xA5, receive 0x3C LSB first.
    run_cycle(pat_tx, 1'b1, 1'b0, 8'h00, 1'b1);
    check_val("reset serial_out lane0", {31'b0, snap_so_a}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      run_cycle(8'h00, 1'b0, 1'b1, {8{pat_rx[k]}}, 1'b1);
      check_val($sformatf("directed serial_out beat%0d", k), {31'b0, snap_so_a},
                {31'b0, pat_tx[k]});
    end
    run_cycle(8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    check_val("directed rx_data", {24'b0, snap_rxd_a}, 32'h3C);
    check_val("directed rx_valid", {31'b0, snap_rxv_a}, 32'd1);
    check_val("directed frame_done", {31'b0, snap_fd_a}, 32'd1);
    check_val("directed busy", {31'b0, snap_busy_a}, 32'd0);
    run_cycle(8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    check_val("directed frame_done pulse", {31'b0, snap_fd_a}, 32'd0);

    // Random traffic with occasional mid-frame resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 249) == 0) pulse_reset();
      run_cycle(8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
                8'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
